// File: rtl/game_state_controller.sv
// Game-level FSM: arming/start, lives, death/respawn delay with blinking
// lives display, game over and level count. All outputs are registered.
module game_state_controller #(
  parameter logic [3:0]  C_LIVES_INI    = 4'b1111,
  parameter int unsigned C_DEATH_DELAY  = 25000000,
  parameter int unsigned C_BLINK_PERIOD = 3125000,
  parameter int unsigned C_MAX_LEVEL    = 9
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  input  logic       i_Has_Collided,
  input  logic       i_Level_Up,
  output logic       o_Game_Active,
  output logic [3:0] o_Lives,
  output logic [3:0] o_Level,
  output logic       o_Death_Pulse,
  output logic       o_Respawn,
  output logic       o_Blink,
  output logic       o_Game_Over
);

  localparam int unsigned      DLY_W    = $clog2(C_DEATH_DELAY);
  localparam int unsigned      BLK_W    = $clog2(C_BLINK_PERIOD + 1);
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(C_DEATH_DELAY - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(C_BLINK_PERIOD - 1);
  localparam logic [3:0]       LVL_MAX  = 4'(C_MAX_LEVEL);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUNNING   = 2'd1,
    S_DYING     = 2'd2,
    S_GAME_OVER = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             armed_q, armed_d;
  logic [3:0]       lives_q, lives_d;
  logic [3:0]       level_q, level_d;
  logic             blink_q, blink_d;
  logic             death_pulse_q, death_pulse_d;
  logic             respawn_q, respawn_d;
  logic [DLY_W-1:0] delay_cnt_q, delay_cnt_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             game_active_q, game_active_d;
  logic             game_over_q, game_over_d;
  logic [3:0]       lives_out_q, lives_out_d;

  // Next-state, counters and registered-output values
  always_comb begin
    state_d       = state_q;
    armed_d       = armed_q;
    lives_d       = lives_q;
    level_d       = level_q;
    blink_d       = blink_q;
    death_pulse_d = 1'b0;
    respawn_d     = 1'b0;
    delay_cnt_d   = delay_cnt_q;
    blink_cnt_d   = blink_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (!i_Start) armed_d = 1'b1;
        if (armed_q && i_Start) state_d = S_RUNNING;
      end
      S_RUNNING: begin
        if (i_Has_Collided) begin
          death_pulse_d = 1'b1;
          if (lives_q != 4'd0) lives_d = lives_q >> 1;
          if (lives_d == 4'd0) begin
            state_d = S_GAME_OVER;
            armed_d = 1'b0;
          end else begin
            state_d     = S_DYING;
            delay_cnt_d = DLY_LOAD;
            blink_cnt_d = '0;
            blink_d     = 1'b1;
          end
        end else if (i_Level_Up && (level_q < LVL_MAX)) begin
          level_d = level_q + 4'd1;
        end
      end
      S_DYING: begin
        if (delay_cnt_q == '0) begin
          state_d   = S_IDLE;
          armed_d   = 1'b0;
          respawn_d = 1'b1;
          blink_d   = 1'b1;
        end else begin
          delay_cnt_d = delay_cnt_q - 1'b1;
          if (blink_cnt_q == BLK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
      end
      S_GAME_OVER: begin
        if (!i_Start) armed_d = 1'b1;
        if (armed_q && i_Start) begin
          state_d   = S_IDLE;
          armed_d   = 1'b0;
          lives_d   = C_LIVES_INI;
          level_d   = 4'd0;
          respawn_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        armed_d = 1'b0;
      end
    endcase

    // Outputs follow the next state so they line up with it after the edge
    game_active_d = (state_d == S_RUNNING);
    game_over_d   = (state_d == S_GAME_OVER);
    if (state_d == S_GAME_OVER)             lives_out_d = 4'd0;
    else if (state_d == S_DYING && !blink_d) lives_out_d = 4'd0;
    else                                     lives_out_d = lives_d;
  end

  // State and output registers, async reset to power-up values
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q       <= S_IDLE;
      armed_q       <= 1'b0;
      lives_q       <= C_LIVES_INI;
      level_q       <= 4'd0;
      blink_q       <= 1'b1;
      death_pulse_q <= 1'b0;
      respawn_q     <= 1'b0;
      delay_cnt_q   <= '0;
      blink_cnt_q   <= '0;
      game_active_q <= 1'b0;
      game_over_q   <= 1'b0;
      lives_out_q   <= C_LIVES_INI;
    end else begin
      state_q       <= state_d;
      armed_q       <= armed_d;
      lives_q       <= lives_d;
      level_q       <= level_d;
      blink_q       <= blink_d;
      death_pulse_q <= death_pulse_d;
      respawn_q     <= respawn_d;
      delay_cnt_q   <= delay_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      game_active_q <= game_active_d;
      game_over_q   <= game_over_d;
      lives_out_q   <= lives_out_d;
    end
  end

  assign o_Game_Active = game_active_q;
  assign o_Lives       = lives_out_q;
  assign o_Level       = level_q;
  assign o_Death_Pulse = death_pulse_q;
  assign o_Respawn     = respawn_q;
  assign o_Blink       = blink_q;
  assign o_Game_Over   = game_over_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller (short delay/blink parameters).
module tb_game_state_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       coll;
  logic       lvl_up;
  logic       game_active;
  logic [3:0] lives;
  logic [3:0] level;
  logic       death_pulse;
  logic       respawn;
  logic       blink;
  logic       game_over;

  int checks   = 0;
  int failures = 0;

  game_state_controller #(
    .C_LIVES_INI   (4'b1111),
    .C_DEATH_DELAY (8),
    .C_BLINK_PERIOD(2),
    .C_MAX_LEVEL   (3)
  ) dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_Start       (start),
    .i_Has_Collided(coll),
    .i_Level_Up    (lvl_up),
    .o_Game_Active (game_active),
    .o_Lives       (lives),
    .o_Level       (level),
    .o_Death_Pulse (death_pulse),
    .o_Respawn     (respawn),
    .o_Blink       (blink),
    .o_Game_Over   (game_over)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release then press start; leaves start released afterwards.
  task automatic do_start();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One-cycle collision; then wait (bounded) for respawn unless game over.
  task automatic kill(output bit ok);
    coll = 1'b1;
    tick();
    coll = 1'b0;
    ok = 1'b0;
    if (game_over) ok = 1'b1;
    else begin
      for (int i = 0; i < 20; i++) begin
        tick();
        if (respawn) begin
          ok = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; coll = 1'b0; lvl_up = 1'b0;
    tick(); tick();
    checks++; if (lives !== 4'b1111) begin failures++; $display("FAIL reset_lives got=%b exp=1111", lives); end
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if ({game_active, game_over, death_pulse, respawn, blink} !== 5'b00001) begin
      failures++; $display("FAIL reset_flags got=%b exp=00001", {game_active, game_over, death_pulse, respawn, blink}); end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (game_active !== 1'b0) begin failures++; $display("FAIL held_start_no_run got=%b exp=0", game_active); end
  endtask

  task automatic test_start();
    start = 1'b0;
    tick();
    checks++; if (game_active !== 1'b0) begin failures++; $display("FAIL arm_no_run got=%b exp=0", game_active); end
    start = 1'b1;
    tick();
    checks++; if (game_active !== 1'b1) begin failures++; $display("FAIL start_run got=%b exp=1", game_active); end
    start = 1'b0;
  endtask

  task automatic test_death();
    logic [8:0] blink_exp;
    int pulses;
    int resp_at;
    int resp_cnt;
    blink_exp = 9'b1_0011_0011;
    coll = 1'b1;
    tick();
    checks++; if (death_pulse !== 1'b1) begin failures++; $display("FAIL death_pulse got=%b exp=1", death_pulse); end
    checks++; if (lives !== 4'b0111) begin failures++; $display("FAIL death_lives got=%b exp=0111", lives); end
    checks++; if (game_active !== 1'b0) begin failures++; $display("FAIL death_inactive got=%b exp=0", game_active); end
    checks++; if (blink !== 1'b1) begin failures++; $display("FAIL blink_c1 got=%b exp=1", blink); end
    pulses = 1; resp_at = 0; resp_cnt = 0;
    for (int i = 2; i <= 20; i++) begin
      tick();
      if (death_pulse) pulses++;
      if (respawn) begin
        resp_cnt++;
        if (resp_at == 0) resp_at = i;
      end
      if (i <= 9) begin
        checks++; if (blink !== blink_exp[i-1]) begin
          failures++; $display("FAIL blink_c%0d got=%b exp=%b", i, blink, blink_exp[i-1]); end
        checks++; if (lives !== ((i <= 8 && !blink_exp[i-1]) ? 4'b0000 : 4'b0111)) begin
          failures++; $display("FAIL dying_lives_c%0d got=%b", i, lives); end
      end
    end
    coll = 1'b0;
    checks++; if (pulses !== 1) begin failures++; $display("FAIL one_death_pulse got=%0d exp=1", pulses); end
    checks++; if (resp_at !== 9 || resp_cnt !== 1) begin
      failures++; $display("FAIL respawn_timing got_at=%0d got_cnt=%0d exp_at=9 exp_cnt=1", resp_at, resp_cnt); end
    checks++; if (lives !== 4'b0111) begin failures++; $display("FAIL lives_after_respawn got=%b exp=0111", lives); end
  endtask

  task automatic test_game_over();
    bit ok;
    for (int k = 0; k < 3; k++) begin
      do_start();
      kill(ok);
      checks++; if (!ok) begin failures++; $display("FAIL go_kill%0d_timeout got=0 exp=1", k); end
    end
    checks++; if (game_over !== 1'b1) begin failures++; $display("FAIL game_over got=%b exp=1", game_over); end
    checks++; if (lives !== 4'b0000) begin failures++; $display("FAIL go_lives got=%b exp=0000", lives); end
    start = 1'b1;
    tick(); tick();
    checks++; if (game_over !== 1'b1) begin failures++; $display("FAIL go_no_autorestart got=%b exp=1", game_over); end
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (game_over !== 1'b0 || game_active !== 1'b0) begin
      failures++; $display("FAIL go_exit_idle got=%b%b exp=00", game_over, game_active); end
    checks++; if (lives !== 4'b1111) begin failures++; $display("FAIL go_new_lives got=%b exp=1111", lives); end
    checks++; if (level !== 4'd0) begin failures++; $display("FAIL go_new_level got=%0d exp=0", level); end
    checks++; if (respawn !== 1'b1) begin failures++; $display("FAIL go_respawn got=%b exp=1", respawn); end
  endtask

  task automatic test_level();
    logic [3:0] exp_lv [5];
    exp_lv = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3};
    do_start();
    checks++; if (game_active !== 1'b1) begin failures++; $display("FAIL lvl_start got=%b exp=1", game_active); end
    for (int k = 0; k < 5; k++) begin
      lvl_up = 1'b1;
      tick();
      lvl_up = 1'b0;
      checks++; if (level !== exp_lv[k]) begin
        failures++; $display("FAIL level_up%0d got=%0d exp=%0d", k, level, exp_lv[k]); end
      tick();
    end
    lvl_up = 1'b1; coll = 1'b1;
    tick();
    lvl_up = 1'b0; coll = 1'b0;
    checks++; if (level !== 4'd3) begin failures++; $display("FAIL same_cycle_level got=%0d exp=3", level); end
    checks++; if (death_pulse !== 1'b1 || lives !== 4'b0111) begin
      failures++; $display("FAIL same_cycle_death got=%b/%b exp=1/0111", death_pulse, lives); end
  endtask

  task automatic test_ignore();
    bit seen;
    lvl_up = 1'b1; coll = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (level !== 4'd3 || death_pulse !== 1'b0) begin
        failures++; $display("FAIL dying_ignore%0d got=%0d/%b exp=3/0", k, level, death_pulse); end
      checks++; if (lives !== (blink ? 4'b0111 : 4'b0000)) begin
        failures++; $display("FAIL dying_ignore_lives%0d got=%b", k, lives); end
    end
    lvl_up = 1'b0; coll = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (respawn) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL ignore_respawn_timeout got=0 exp=1"); end
    lvl_up = 1'b1; coll = 1'b1;
    tick(); tick();
    lvl_up = 1'b0; coll = 1'b0;
    checks++; if (level !== 4'd3 || lives !== 4'b0111 || game_active !== 1'b0) begin
      failures++; $display("FAIL idle_ignore got=%0d/%b/%b exp=3/0111/0", level, lives, game_active); end
  endtask

  task automatic test_reset_dying();
    int resp_cnt;
    do_start();
    coll = 1'b1;
    tick();
    coll = 1'b0;
    checks++; if (death_pulse !== 1'b1) begin failures++; $display("FAIL rd_death got=%b exp=1", death_pulse); end
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    checks++; if (lives !== 4'b1111) begin failures++; $display("FAIL rd_lives got=%b exp=1111", lives); end
    checks++; if (level !== 4'd0 || blink !== 1'b1) begin
      failures++; $display("FAIL rd_level_blink got=%0d/%b exp=0/1", level, blink); end
    tick(); tick();
    rst = 1'b0;
    resp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (respawn) resp_cnt++;
    end
    checks++; if (resp_cnt !== 0 || game_active !== 1'b0) begin
      failures++; $display("FAIL rd_no_respawn got=%0d/%b exp=0/0", resp_cnt, game_active); end
  endtask

  task automatic test_game_over_ignore();
    bit ok;
    do_start();
    lvl_up = 1'b1;
    tick();
    lvl_up = 1'b0;
    checks++; if (level !== 4'd1) begin failures++; $display("FAIL goi_level got=%0d exp=1", level); end
    kill(ok);
    for (int k = 0; k < 3; k++) begin
      do_start();
      kill(ok);
    end
    checks++; if (game_over !== 1'b1 || !ok) begin failures++; $display("FAIL goi_reach got=%b exp=1", game_over); end
    lvl_up = 1'b1; coll = 1'b1;
    tick(); tick();
    lvl_up = 1'b0; coll = 1'b0;
    checks++; if (level !== 4'd1 || lives !== 4'b0000 || game_over !== 1'b1) begin
      failures++; $display("FAIL goi_ignore got=%0d/%b/%b exp=1/0000/1", level, lives, game_over); end
    do_start();
    checks++; if (respawn !== 1'b1 || lives !== 4'b1111 || level !== 4'd0) begin
      failures++; $display("FAIL goi_restart got=%b/%b/%0d exp=1/1111/0", respawn, lives, level); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_death();
    test_game_over();
    test_level();
    test_ignore();
    test_reset_dying();
    test_game_over_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
